// File: rtl/grf_wb.sv
// 32 x 32-bit general register file at the end of writeback.
// Read ports can bypass same-cycle write data. Also holds a pending-producer scoreboard and a one-cycle commit trace.
module grf_wb #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [4:0]       WriteAddr,
    input  logic [31:0]      WriteData,
    input  logic [31:0]      wb_pc,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    input  logic             issue_valid,
    input  logic [4:0]       issue_addr,
    output logic             busy1,
    output logic             busy2,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] retire_cnt
);
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;
    logic            w_commit;
    logic            w_hit1;
    logic            w_hit2;

    // Writes to $0 are dropped entirely.
    assign w_commit = we && (WriteAddr != AW'(0));
    assign w_hit1   = BYPASS && w_commit && (WriteAddr == ra1);
    assign w_hit2   = BYPASS && w_commit && (WriteAddr == ra2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[WriteAddr] <= WriteData;
        end
    end

    always_comb begin
        rd1 = r_regs[ra1];
        if (ra1 == AW'(0)) begin
            rd1 = '0;
        end else if (w_hit1) begin
            rd1 = WriteData;
        end
    end

    always_comb begin
        rd2 = r_regs[ra2];
        if (ra2 == AW'(0)) begin
            rd2 = '0;
        end else if (w_hit2) begin
            rd2 = WriteData;
        end
    end

    // A newer issue to the same register outranks the commit clearing it.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_commit) begin
            w_pending_nxt[WriteAddr] = 1'b0;
        end
        if (issue_valid && (issue_addr != AW'(0))) begin
            w_pending_nxt[issue_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign busy1 = (ra1 != AW'(0)) && r_pending[ra1] && !w_hit1;
    assign busy2 = (ra2 != AW'(0)) && r_pending[ra2] && !w_hit2;

    // Trace fields hold between commits; only the valid strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
            retire_cnt  <= '0;
        end else begin
            trace_valid <= w_commit;
            if (w_commit) begin
                trace_pc   <= wb_pc;
                trace_addr <= WriteAddr;
                trace_data <= WriteData;
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_grf_wb.sv
// Bench for grf_wb: a bypassing 32-bit-counter instance and a non-bypassing 2-bit-counter instance share stimulus.
module tb_grf_wb;
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [31:0] wb_pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        issue_valid;
    logic [4:0]  issue_addr;

    logic [31:0] rd1_a, rd2_a, trace_pc_a, trace_data_a, retire_cnt_a;
    logic [31:0] rd1_b, rd2_b, trace_pc_b, trace_data_b;
    logic [1:0]  retire_cnt_b;
    logic [4:0]  trace_addr_a, trace_addr_b;
    logic        busy1_a, busy2_a, trace_valid_a;
    logic        busy1_b, busy2_b, trace_valid_b;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] m_cnt;
    trace_t      exp_q [$];

    always #5 clk = ~clk;

    grf_wb #(.BYPASS(1'b1), .CNT_W(32)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .wb_pc(wb_pc), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .busy1(busy1_a), .busy2(busy2_a),
        .trace_valid(trace_valid_a), .trace_pc(trace_pc_a), .trace_addr(trace_addr_a),
        .trace_data(trace_data_a), .retire_cnt(retire_cnt_a)
    );

    grf_wb #(.BYPASS(1'b0), .CNT_W(2)) u_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .wb_pc(wb_pc), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .busy1(busy1_b), .busy2(busy2_b),
        .trace_valid(trace_valid_b), .trace_pc(trace_pc_b), .trace_addr(trace_addr_b),
        .trace_data(trace_data_b), .retire_cnt(retire_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 32'd0;
        if (byp && we && (WriteAddr == ra)) return WriteData;
        return m_regs[ra];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] ra, input bit byp);
        logic b;
        b = (ra != 5'd0) && m_pend[ra] && !(byp && we && (WriteAddr == ra));
        return 32'(b);
    endfunction

    task automatic check_reads(input string tag);
        chk({tag, ":rd1_byp"},   rd1_a,          exp_rd(ra1, 1'b1));
        chk({tag, ":rd2_byp"},   rd2_a,          exp_rd(ra2, 1'b1));
        chk({tag, ":busy1_byp"}, 32'(busy1_a),   exp_busy(ra1, 1'b1));
        chk({tag, ":busy2_byp"}, 32'(busy2_a),   exp_busy(ra2, 1'b1));
        chk({tag, ":rd1_nob"},   rd1_b,          exp_rd(ra1, 1'b0));
        chk({tag, ":rd2_nob"},   rd2_b,          exp_rd(ra2, 1'b0));
        chk({tag, ":busy1_nob"}, 32'(busy1_b),   exp_busy(ra1, 1'b0));
        chk({tag, ":busy2_nob"}, 32'(busy2_b),   exp_busy(ra2, 1'b0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = 32'd0;
        m_cnt  = 32'd0;
        exp_q.delete();
    endtask

    // One clock: drive, check combinational reads, take the edge, check trace and counter.
    task automatic cyc(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] pc, input logic iv, input logic [4:0] ia);
        trace_t it;
        ra1 = r1; ra2 = r2; we = w; WriteAddr = wa; WriteData = wd; wb_pc = pc;
        issue_valid = iv; issue_addr = ia;
        #1;
        check_reads({tag, ":pre"});
        if (w && wa != 5'd0) exp_q.push_back('{pc: pc, addr: wa, data: wd});
        @(posedge clk);
        if (w && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
            m_cnt      = m_cnt + 32'd1;
        end
        if (iv && ia != 5'd0) m_pend[ia] = 1'b1;
        #1;
        chk({tag, ":tv_byp"}, 32'(trace_valid_a), 32'(exp_q.size() != 0));
        chk({tag, ":tv_nob"}, 32'(trace_valid_b), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            if (trace_valid_a) begin
                chk({tag, ":tpc_byp"},  trace_pc_a,         it.pc);
                chk({tag, ":taddr_byp"}, 32'(trace_addr_a), 32'(it.addr));
                chk({tag, ":tdata_byp"}, trace_data_a,      it.data);
            end
            if (trace_valid_b) begin
                chk({tag, ":tpc_nob"},  trace_pc_b,         it.pc);
                chk({tag, ":taddr_nob"}, 32'(trace_addr_b), 32'(it.addr));
                chk({tag, ":tdata_nob"}, trace_data_b,      it.data);
            end
        end
        chk({tag, ":cnt_byp"}, retire_cnt_a,      m_cnt);
        chk({tag, ":cnt_nob"}, 32'(retire_cnt_b), 32'(m_cnt[1:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b0; we = 1'b1; WriteAddr = 5'd5; WriteData = 32'hDEADBEEF; wb_pc = 32'h3000;
        ra1 = 5'd5; ra2 = 5'd5; issue_valid = 1'b1; issue_addr = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst:tv",       32'(trace_valid_a), 32'd0);
        chk("rst:cnt",      retire_cnt_a,       32'd0);
        chk("rst:rd1_nob",  rd1_b,              32'd0);
        chk("rst:busy1",    32'(busy1_a),       32'd0);
        we = 1'b0; issue_valid = 1'b0;
        #1;
        check_reads("rst");
        rst_n = 1'b1;

        cyc("first",   5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h3000, 1'b0, 5'd0);
        cyc("first_i", 5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0);

        cyc("zero_w",  5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 32'h3004, 1'b1, 5'd0);
        cyc("zero_i",  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0);

        cyc("byp_set", 5'd8, 5'd8, 1'b1, 5'd8, 32'h11,       32'h3008, 1'b0, 5'd0);
        cyc("byp_hit", 5'd8, 5'd8, 1'b1, 5'd8, 32'h22,       32'h300C, 1'b0, 5'd0);
        cyc("byp_aft", 5'd8, 5'd8, 1'b0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0);

        cyc("sb_iss",  5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        32'h0,    1'b1, 5'd9);
        cyc("sb_clr",  5'd9, 5'd9, 1'b1, 5'd9, 32'h99,       32'h3010, 1'b0, 5'd0);
        cyc("sb_aft",  5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        32'h0,    1'b0, 5'd0);

        cyc("col_iss", 5'd10, 5'd10, 1'b0, 5'd0,  32'h0,     32'h0,    1'b1, 5'd10);
        cyc("col_both",5'd10, 5'd10, 1'b1, 5'd10, 32'h55,    32'h3014, 1'b1, 5'd10);
        cyc("col_aft", 5'd10, 5'd10, 1'b0, 5'd0,  32'h0,     32'h0,    1'b0, 5'd0);
        cyc("diff",    5'd10, 5'd7,  1'b1, 5'd10, 32'h66,    32'h3018, 1'b1, 5'd7);
        cyc("diff_aft",5'd10, 5'd7,  1'b0, 5'd0,  32'h0,     32'h0,    1'b0, 5'd0);

        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("stream%0d", i), 5'(i + 1), 5'(i + 1), 1'b1, 5'(i + 1),
                32'hA0 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0, 5'd0);
        end
        cyc("stream_end", 5'd4, 5'd3, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);

        for (int i = 0; i < 40; i++) begin
            cyc($sformatf("rnd%0d", i), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset in the middle of a cycle with a write and issue in flight.
        cyc("pre_mid", 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3);
        we = 1'b1; WriteAddr = 5'd3; WriteData = 32'hCAFE0000; issue_valid = 1'b1; issue_addr = 5'd4;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid:tv",    32'(trace_valid_a), 32'd0);
        chk("mid:cnt",   retire_cnt_a,       32'd0);
        chk("mid:cnt_b", 32'(retire_cnt_b),  32'd0);
        chk("mid:rd1",   rd1_b,              32'd0);
        chk("mid:busy1", 32'(busy1_b),       32'd0);
        @(posedge clk);
        #1;
        chk("mid:tv_edge", 32'(trace_valid_a), 32'd0);
        rst_n = 1'b1;
        cyc("post_mid", 5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
